memory_arbiter: RTL and testbench

MEMORY_ARBITER -- requirements
Module: memory_arbiter

---
 rtl/memory_arbiter_pkg.sv | 20 ++
 rtl/arb_priority_select.sv | 60 ++++++
 rtl/memory_arbiter.sv | 134 +++++++++++++
 tb/tb_memory_arbiter.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/memory_arbiter_pkg.sv
// Shared types and constants for the memory arbiter.
package memory_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    FETCH_ACC = 2'd1,
    DATA_ACC  = 2'd2
  } arb_state_e;

  localparam logic SEL_FETCH = 1'b0;
  localparam logic SEL_DATA  = 1'b1;

  localparam int STARVE_LIMIT_DEFAULT = 4;

  // Width of a counter that must reach the value 'limit'.
  function automatic int starve_cnt_w(input int limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/arb_priority_select.sv
// Winner selection between fetch and data ports.
// Data has fixed priority. With MEM_ARB_STARVE_GUARD_EN defined, a saturating
// counter of consecutive fetch losses lets fetch win once it reaches STARVE_LIMIT.
import memory_arbiter_pkg::*;

module arb_priority_select #(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic arb_en_i,
  input  logic fetch_req_i,
  input  logic data_req_i,
  output logic win_vld_o,
  output logic win_sel_o
);

  assign win_vld_o = arb_en_i & (fetch_req_i | data_req_i);

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam int CW = starve_cnt_w(STARVE_LIMIT);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  logic [CW-1:0] starve_cnt_q, starve_cnt_d;
  logic          starved;

  assign starved = (starve_cnt_q == LIMIT);

  // Data wins contention unless fetch has already lost LIMIT times in a row.
  always_comb begin
    win_sel_o = SEL_FETCH;
    if (data_req_i && !(fetch_req_i && starved)) win_sel_o = SEL_DATA;
  end

  // Count fetch losses during arbitration; clear on a fetch win, saturate at LIMIT.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (win_vld_o && fetch_req_i) begin
      if (win_sel_o == SEL_FETCH) starve_cnt_d = '0;
      else if (!starved)          starve_cnt_d = starve_cnt_q + 1'b1;
    end
  end

  // Counter register, cleared by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) starve_cnt_q <= '0;
    else        starve_cnt_q <= starve_cnt_d;
  end
`else
  // Plain fixed priority: data always wins contention.
  always_comb begin
    win_sel_o = data_req_i ? SEL_DATA : SEL_FETCH;
  end

  // Clock, reset and limit are only needed by the starvation counter.
  logic unused_guard;
  assign unused_guard = clk ^ reset ^ (STARVE_LIMIT < 0);
`endif

endmodule

// File: rtl/memory_arbiter.sv
// Two-port (fetch/data) arbiter in front of a single-cycle memory.
// One access per two cycles: gnt at T, memory access at T+1, rvalid at T+2.
// Optional starvation guard: define MEM_ARB_STARVE_GUARD_EN.
import memory_arbiter_pkg::*;

module memory_arbiter #(
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fetch_req_i,
  input  logic [DATA_WIDTH-1:0] fetch_addr_i,
  output logic                  fetch_gnt_o,
  output logic                  fetch_rvalid_o,
  output logic [DATA_WIDTH-1:0] fetch_rdata_o,
  input  logic                  data_req_i,
  input  logic                  data_we_i,
  input  logic [DATA_WIDTH-1:0] data_addr_i,
  input  logic [DATA_WIDTH-1:0] data_wdata_i,
  output logic                  data_gnt_o,
  output logic                  data_rvalid_o,
  output logic [DATA_WIDTH-1:0] data_rdata_o,
  output logic [DATA_WIDTH-1:0] mem_address_o,
  output logic [DATA_WIDTH-1:0] mem_write_data_o,
  output logic                  mem_write_enable_o,
  input  logic [DATA_WIDTH-1:0] mem_instruction_i,
  output logic                  busy_o
);

  arb_state_e            state_q, state_d;
  logic [DATA_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  we_q, we_d;
  logic                  fetch_rvalid_q, fetch_rvalid_d;
  logic                  data_rvalid_q, data_rvalid_d;
  logic [DATA_WIDTH-1:0] fetch_rdata_q, fetch_rdata_d;
  logic [DATA_WIDTH-1:0] data_rdata_q, data_rdata_d;

  logic win_vld, win_sel;
  logic in_idle;

  assign in_idle = (state_q == IDLE);

  arb_priority_select #(.STARVE_LIMIT(STARVE_LIMIT)) u_sel (
    .clk        (clk),
    .reset      (reset),
    .arb_en_i   (in_idle),
    .fetch_req_i(fetch_req_i),
    .data_req_i (data_req_i),
    .win_vld_o  (win_vld),
    .win_sel_o  (win_sel)
  );

  // Next state: latch the winner in IDLE, complete the access after one ACC cycle.
  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    we_d           = we_q;
    fetch_rvalid_d = 1'b0;
    data_rvalid_d  = 1'b0;
    fetch_rdata_d  = fetch_rdata_q;
    data_rdata_d   = data_rdata_q;
    case (state_q)
      IDLE: begin
        if (win_vld) begin
          if (win_sel == SEL_DATA) begin
            state_d = DATA_ACC;
            addr_d  = data_addr_i;
            wdata_d = data_wdata_i;
            we_d    = data_we_i;
          end else begin
            state_d = FETCH_ACC;
            addr_d  = fetch_addr_i;
            wdata_d = '0;
            we_d    = 1'b0;
          end
        end
      end
      FETCH_ACC: begin
        state_d        = IDLE;
        fetch_rvalid_d = 1'b1;
        fetch_rdata_d  = mem_instruction_i;
      end
      DATA_ACC: begin
        state_d       = IDLE;
        data_rvalid_d = 1'b1;
        // Writes are acknowledged but keep the previous load data.
        if (!we_q) data_rdata_d = mem_instruction_i;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any access in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      addr_q         <= '0;
      wdata_q        <= '0;
      we_q           <= 1'b0;
      fetch_rvalid_q <= 1'b0;
      data_rvalid_q  <= 1'b0;
      fetch_rdata_q  <= '0;
      data_rdata_q   <= '0;
    end else begin
      state_q        <= state_d;
      addr_q         <= addr_d;
      wdata_q        <= wdata_d;
      we_q           <= we_d;
      fetch_rvalid_q <= fetch_rvalid_d;
      data_rvalid_q  <= data_rvalid_d;
      fetch_rdata_q  <= fetch_rdata_d;
      data_rdata_q   <= data_rdata_d;
    end
  end

  // Grants are combinational pulses in IDLE, held low while reset is asserted.
  assign fetch_gnt_o = reset & win_vld & (win_sel == SEL_FETCH);
  assign data_gnt_o  = reset & win_vld & (win_sel == SEL_DATA);

  assign fetch_rvalid_o = fetch_rvalid_q;
  assign data_rvalid_o  = data_rvalid_q;
  assign fetch_rdata_o  = fetch_rdata_q;
  assign data_rdata_o   = data_rdata_q;

  // Memory bus is only driven during an access.
  assign mem_address_o      = in_idle ? '0 : addr_q;
  assign mem_write_data_o   = in_idle ? '0 : wdata_q;
  assign mem_write_enable_o = (state_q == DATA_ACC) & we_q;
  assign busy_o             = ~in_idle;

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed self-checking bench for memory_arbiter.
module tb_memory_arbiter;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          fetch_req, data_req, data_we;
  logic [DW-1:0] fetch_addr, data_addr, data_wdata, mem_instr;
  logic          fetch_gnt, fetch_rvalid, data_gnt, data_rvalid, mem_we, busy;
  logic [DW-1:0] fetch_rdata, data_rdata, mem_addr, mem_wdata;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  memory_arbiter #(.DATA_WIDTH(DW), .STARVE_LIMIT(4)) dut (
    .clk               (clk),
    .reset             (reset),
    .fetch_req_i       (fetch_req),
    .fetch_addr_i      (fetch_addr),
    .fetch_gnt_o       (fetch_gnt),
    .fetch_rvalid_o    (fetch_rvalid),
    .fetch_rdata_o     (fetch_rdata),
    .data_req_i        (data_req),
    .data_we_i         (data_we),
    .data_addr_i       (data_addr),
    .data_wdata_i      (data_wdata),
    .data_gnt_o        (data_gnt),
    .data_rvalid_o     (data_rvalid),
    .data_rdata_o      (data_rdata),
    .mem_address_o     (mem_addr),
    .mem_write_data_o  (mem_wdata),
    .mem_write_enable_o(mem_we),
    .mem_instruction_i (mem_instr),
    .busy_o            (busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // Starts and ends at posedge+1 of an IDLE cycle.
  task automatic do_fetch(input logic [DW-1:0] a, input logic [DW-1:0] d);
    fetch_req = 1'b1; fetch_addr = a; mem_instr = d;
    smp();
    chk("f_gnt", fetch_gnt, 1);
    chk("f_dgnt", data_gnt, 0);
    chk("f_busy_idle", busy, 0);
    tick(); fetch_req = 1'b0;
    smp();
    chk("f_addr", mem_addr, a);
    chk("f_busy", busy, 1);
    chk("f_we", mem_we, 0);
    chk("f_gnt_acc", fetch_gnt, 0);
    tick(); smp();
    chk("f_rvalid", fetch_rvalid, 1);
    chk("f_rdata", fetch_rdata, d);
    chk("f_addr_idle", mem_addr, 0);
    tick(); mem_instr = 32'h0BAD_0BAD;
    smp();
    chk("f_rvalid_pulse", fetch_rvalid, 0);
    chk("f_rdata_hold", fetch_rdata, d);
    tick();
  endtask

  initial begin
    logic exp_f, prev_f;
    int   prev_port;

    reset = 1'b0;
    fetch_req = 0; data_req = 0; data_we = 0;
    fetch_addr = '0; data_addr = '0; data_wdata = '0; mem_instr = '0;

    // Reset state: requests are ignored and every output is 0
    tick(); fetch_req = 1'b1; fetch_addr = 32'h0040_0000; data_req = 1'b1;
    smp();
    chk("rst_fgnt", fetch_gnt, 0);
    chk("rst_dgnt", data_gnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_maddr", mem_addr, 0);
    chk("rst_mwe", mem_we, 0);
    chk("rst_frv", fetch_rvalid, 0);
    chk("rst_drv", data_rvalid, 0);
    chk("rst_frd", fetch_rdata, 0);
    chk("rst_drd", data_rdata, 0);
    tick(); fetch_req = 0; data_req = 0; reset = 1'b1;
    tick();

    // Fetch only
    do_fetch(32'h0040_0004, 32'h2008_0005);

    // Data read, so data_rdata holds a known value before the write
    data_req = 1; data_we = 0; data_addr = 32'h1001_0004; mem_instr = 32'h1122_3344;
    smp(); chk("dr_gnt", data_gnt, 1);
    tick(); data_req = 0;
    smp(); chk("dr_addr", mem_addr, 32'h1001_0004); chk("dr_we", mem_we, 0);
    tick(); smp();
    chk("dr_rvalid", data_rvalid, 1);
    chk("dr_rdata", data_rdata, 32'h1122_3344);
    chk("dr_frv", fetch_rvalid, 0);
    tick();

    // Data write: one cycle of write enable, rdata unchanged
    data_req = 1; data_we = 1; data_addr = 32'h1001_0000; data_wdata = 32'hDEAD_BEEF;
    mem_instr = 32'h5555_AAAA;
    smp(); chk("dw_gnt", data_gnt, 1); chk("dw_we_idle", mem_we, 0);
    tick(); data_req = 0; data_we = 0;
    smp();
    chk("dw_we", mem_we, 1);
    chk("dw_addr", mem_addr, 32'h1001_0000);
    chk("dw_wdata", mem_wdata, 32'hDEAD_BEEF);
    tick(); smp();
    chk("dw_we_off", mem_we, 0);
    chk("dw_wdata_idle", mem_wdata, 0);
    chk("dw_rvalid", data_rvalid, 1);
    chk("dw_rdata_hold", data_rdata, 32'h1122_3344);
    tick();

    // Contention: both ports request continuously
    fetch_req = 1; data_req = 1; data_we = 0;
    fetch_addr = 32'h0040_0100; data_addr = 32'h1001_0100; mem_instr = 32'h0000_00C5;
    prev_f = 1'b0;
    for (int k = 0; k < 20; k++) begin
      smp();
      if (k % 2 == 0) begin
`ifdef MEM_ARB_STARVE_GUARD_EN
        exp_f = ((k / 2) % 5 == 4);
`else
        exp_f = 1'b0;
`endif
        chk($sformatf("ct_fgnt%0d", k / 2), fetch_gnt, exp_f);
        chk($sformatf("ct_dgnt%0d", k / 2), data_gnt, !exp_f);
        if (k > 0) begin
          chk($sformatf("ct_frv%0d", k / 2), fetch_rvalid, prev_f);
          chk($sformatf("ct_drv%0d", k / 2), data_rvalid, !prev_f);
        end
        prev_f = exp_f;
      end else begin
        chk($sformatf("ct_gnt_acc%0d", k / 2), {fetch_gnt, data_gnt}, 2'b00);
        chk($sformatf("ct_busy%0d", k / 2), busy, 1);
      end
      tick();
      if (k == 19) begin fetch_req = 0; data_req = 0; end
    end
    smp();
    chk("ct_last_frv", fetch_rvalid, prev_f);
    chk("ct_last_drv", data_rvalid, !prev_f);
    tick();

    // Reset in the middle of a write
    data_req = 1; data_we = 1; data_addr = 32'h1001_0008; data_wdata = 32'h0123_4567;
    smp(); chk("rw_gnt", data_gnt, 1);
    tick(); data_req = 0; data_we = 0;
    smp(); chk("rw_we_pre", mem_we, 1);
    #1 reset = 1'b0;
    #1;
    chk("rw_we_abort", mem_we, 0);
    chk("rw_busy", busy, 0);
    chk("rw_maddr", mem_addr, 0);
    smp();
    chk("rw_no_rvalid", data_rvalid, 0);
    tick(); reset = 1'b1;
    smp();
    chk("rw_no_rvalid2", data_rvalid, 0);
    chk("rw_no_replay", busy, 0);
    chk("rw_drd_clr", data_rdata, 0);
    tick();
    do_fetch(32'h0040_0008, 32'hCAFE_F00D);

    // Alternating requests: gnt every 2 cycles, ports never overlap
    data_we = 0; mem_instr = 32'h0000_0A1F;
    fetch_req = 1; data_req = 0;
    prev_port = -1;
    for (int n = 0; n < 6; n++) begin
      smp();
      chk($sformatf("alt_fgnt%0d", n), fetch_gnt, (n % 2 == 0));
      chk($sformatf("alt_dgnt%0d", n), data_gnt, (n % 2 == 1));
      if (n > 0) begin
        chk($sformatf("alt_frv%0d", n), fetch_rvalid, (prev_port == 0));
        chk($sformatf("alt_drv%0d", n), data_rvalid, (prev_port == 1));
      end
      prev_port = n % 2;
      tick();
      fetch_req = (n < 5) && ((n + 1) % 2 == 0);
      data_req  = (n < 5) && ((n + 1) % 2 == 1);
      smp();
      chk($sformatf("alt_acc%0d", n), {fetch_gnt, data_gnt, busy}, 3'b001);
      tick();
    end
    smp();
    chk("alt_last_drv", data_rvalid, 1);
    chk("alt_last_drd", data_rdata, 32'h0000_0A1F);
    chk("alt_last_frv", fetch_rvalid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
